// File: rtl/demux_tdm_pkg.sv
// Shared types and constants for the 1-bit, 8-slot TDM receive path.
// Optional parity slot is enabled with DEMUX_TDM_PARITY_EN.
package demux_tdm_pkg;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_RECV,
        ST_PAR
    } state_t;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;

    // High when the data plus parity bit hold an odd number of ones.
    function automatic logic par_bad(input logic [NUM_SLOTS-1:0] d,
                                     input logic p);
        return ^{p, d};
    endfunction

endpackage

// File: rtl/demux_tdm_1para8_dec.sv
// 3-to-8 one-hot decoder with enable.
// Generates the per-slot shadow write enables.
module Decoder_3para8 (
    input  logic [2:0] sel,
    input  logic       en,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        if (en) y[sel] = 1'b1;
    end

endmodule

// File: rtl/demux_tdm_1para8.sv
// 1-bit to 8-channel TDM demultiplexer with frame sync and stall timeout.
// Define DEMUX_TDM_PARITY_EN to add a 9th even-parity slot per frame.
module demux_tdm_1para8
    import demux_tdm_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    input  logic                 din_valid,
    input  logic                 sync,
    output logic [NUM_SLOTS-1:0] dout,
    output logic                 dout_valid,
    output logic [SLOT_W-1:0]    slot,
    output logic                 busy,
    output logic                 frame_err
);

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_t                 state;
    state_t                 state_nx;
    logic [NUM_SLOTS-1:0]   shadow;
    logic [NUM_SLOTS-1:0]   shadow_nx;
    logic [NUM_SLOTS-1:0]   we;
    logic [SLOT_W-1:0]      slot_nx;
    logic [SLOT_W-1:0]      dec_sel;
    logic [7:0]             tcnt;
    logic [7:0]             tcnt_nx;
    logic [7:0]             tcnt_inc;
    logic [NUM_SLOTS-1:0]   dout_nx;
    logic                   dv_nx;
    logic                   fe_nx;
    logic                   start;
    logic                   accept;
    logic                   last_slot;
    logic                   timed_out;
    logic                   wr;

    assign start     = din_valid & sync;
    assign accept    = din_valid & ~sync;
    assign last_slot = (slot == SLOT_W'(NUM_SLOTS - 1));
    assign tcnt_inc  = tcnt + 8'd1;
    assign timed_out = ~din_valid & (tcnt_inc == TO_LIM);

    // A sync always lands in slot 0, whatever the current slot is.
    assign wr      = start | ((state == ST_RECV) & accept);
    assign dec_sel = sync ? '0 : slot;

    Decoder_3para8 u_dec (
        .sel (dec_sel),
        .en  (wr),
        .y   (we)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_HUNT;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_HUNT: begin
                if (start) state_nx = ST_RECV;
            end
            ST_RECV: begin
                if (start) begin
                    state_nx = ST_RECV;
                end else if (accept && last_slot) begin
`ifdef DEMUX_TDM_PARITY_EN
                    state_nx = ST_PAR;
`else
                    state_nx = ST_HUNT;
`endif
                end else if (timed_out) begin
                    state_nx = ST_HUNT;
                end
            end
            ST_PAR: begin
                if (start)          state_nx = ST_RECV;
                else if (accept)    state_nx = ST_HUNT;
                else if (timed_out) state_nx = ST_HUNT;
            end
            default: state_nx = ST_HUNT;
        endcase
    end

    always_comb begin
        slot_nx   = slot;
        tcnt_nx   = tcnt;
        dout_nx   = dout;
        dv_nx     = 1'b0;
        fe_nx     = 1'b0;
        shadow_nx = wr ? ((shadow & ~we) | ({NUM_SLOTS{din}} & we)) : shadow;
        unique case (state)
            ST_HUNT: begin
                tcnt_nx = '0;
                slot_nx = start ? SLOT_W'(1) : '0;
            end
            ST_RECV, ST_PAR: begin
                if (start) begin
                    fe_nx   = 1'b1;
                    slot_nx = SLOT_W'(1);
                    tcnt_nx = '0;
                end else if (accept) begin
                    tcnt_nx = '0;
                    slot_nx = slot + SLOT_W'(1);
                    if (state == ST_PAR) begin
                        slot_nx = '0;
                        if (par_bad(shadow, din)) begin
                            fe_nx = 1'b1;
                        end else begin
                            dout_nx = shadow;
                            dv_nx   = 1'b1;
                        end
                    end else if (last_slot) begin
`ifndef DEMUX_TDM_PARITY_EN
                        dout_nx = {din, shadow[NUM_SLOTS-2:0]};
                        dv_nx   = 1'b1;
`endif
                    end
                end else if (timed_out) begin
                    fe_nx   = 1'b1;
                    slot_nx = '0;
                    tcnt_nx = '0;
                end else begin
                    tcnt_nx = tcnt_inc;
                end
            end
            default: begin
                slot_nx = '0;
                tcnt_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            slot       <= '0;
            tcnt       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            shadow     <= shadow_nx;
            slot       <= slot_nx;
            tcnt       <= tcnt_nx;
            dout       <= dout_nx;
            dout_valid <= dv_nx;
            frame_err  <= fe_nx;
            busy       <= (state_nx != ST_HUNT);
        end
    end

endmodule

// File: tb/tb_demux_tdm_1para8.sv
// Scoreboard bench for demux_tdm_1para8; frame-level reference model.
// Build with DEMUX_TDM_PARITY_EN to exercise the parity slot.
module tb_demux_tdm_1para8;

    localparam int TIMEOUT = 16;
`ifdef DEMUX_TDM_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       sync = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic [2:0] slot;
    logic       busy;
    logic       frame_err;

    typedef struct {
        bit         fe;
        logic [7:0] d;
    } ev_t;

    ev_t        expq[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         t_done = 0;
    logic [7:0] last_good = 8'h00;

    demux_tdm_1para8 #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .slot       (slot),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic void push(input bit fe, input logic [7:0] d);
        ev_t e;
        e.fe = fe;
        e.d  = d;
        expq.push_back(e);
    endfunction

    // Monitor: every strobe must match the next expected event.
    always @(negedge clk) begin
        if (rst_n && (dout_valid || frame_err)) begin
            tests++;
            if (dout_valid && frame_err) begin
                fails++;
                $display("FAIL both_strobes: got dv=1 fe=1 required one");
            end else if (expq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got dv=%0b fe=%0b required none",
                         dout_valid, frame_err);
            end else begin
                ev_t e;
                e = expq.pop_front();
                if (e.fe !== frame_err || dout !== e.d) begin
                    fails++;
                    $display("FAIL event: got fe=%0b dout=%0h required fe=%0b dout=%0h",
                             frame_err, dout, e.fe, e.d);
                end
            end
        end
    end

    task automatic drive(input logic b, input logic s);
        din       = b;
        sync      = s;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Idle cycles; sync/din are garbage and must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            din_valid = 1'b0;
            sync      = 1'($urandom);
            din       = 1'($urandom);
            @(posedge clk);
            #1;
        end
        sync = 1'b0;
    endtask

    task automatic send_partial(input logic [7:0] data, input int n);
        logic [8:0] bits;
        bits = {1'b0, data};
        push(1'b1, last_good);
        for (int k = 0; k < n; k++) drive(bits[k], k == 0);
    endtask

    task automatic send_frame(input logic [7:0] data, input int stall_at,
                              input int stall_len, input bit flip);
        logic [8:0] bits;
        bit         bad;
        bits = {(^data) ^ flip, data};
        bad  = (NB == 9) && flip;
        for (int k = 0; k < NB; k++) begin
            if (k == stall_at && k > 0) begin
                if (stall_len >= TIMEOUT) begin
                    push(1'b1, last_good);
                    idle(TIMEOUT);
                    chk("timeout_fe", 32'(frame_err), 32'd1);
                    chk("timeout_busy", 32'(busy), 32'd0);
                    chk("timeout_slot", 32'(slot), 32'd0);
                    idle(stall_len - TIMEOUT);
                    return;
                end
                idle(stall_len);
            end
            drive(bits[k], k == 0);
        end
        if (bad) begin
            push(1'b1, last_good);
        end else begin
            push(1'b0, data);
            last_good = data;
        end
        t_done = cyc;
        chk("done_dv", 32'(dout_valid), 32'(!bad));
        chk("done_fe", 32'(frame_err), 32'(bad));
        chk("done_slot", 32'(slot), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int t1;
        #3;
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_dv", 32'(dout_valid), 32'd0);
        chk("rst_fe", 32'(frame_err), 32'd0);
        chk("rst_slot", 32'(slot), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        send_frame(8'h4D, -1, 0, 1'b0);
        idle(2);
        chk("dout_hold", 32'(dout), 32'h4D);
        send_frame(8'h4D, 4, 3, 1'b0);
        idle(1);
        send_frame(8'h3C, 6, TIMEOUT, 1'b0);
        chk("abort_dout", 32'(dout), 32'(last_good));
        send_partial(8'h99, 4);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_slot", 32'(slot), 32'd4);
        send_frame(8'hA5, -1, 0, 1'b0);
        send_frame(8'hFF, -1, 0, 1'b0);
        t1 = t_done;
        send_frame(8'h01, -1, 0, 1'b0);
        chk("b2b_gap", 32'(t_done - t1), 32'(NB));
        idle(3);
`ifdef DEMUX_TDM_PARITY_EN
        send_frame(8'h03, -1, 0, 1'b0);
        idle(1);
        begin
            logic [8:0] bits;
            bits = {1'b0, 8'h07};
            push(1'b1, last_good);
            for (int k = 0; k < 9; k++) drive(bits[k], k == 0);
            chk("par_fe", 32'(frame_err), 32'd1);
            chk("par_hold", 32'(dout), 32'h03);
        end
        idle(1);
`endif

        for (int it = 0; it < 150; it++) begin
            logic [7:0] d;
            int         sa;
            int         sl;
            int         r;
            d  = 8'($urandom);
            sa = -1;
            sl = 0;
            r  = $urandom_range(0, 9);
            if (r == 0) begin
                send_partial(8'($urandom), $urandom_range(1, NB - 1));
            end
            if (r >= 6) begin
                sa = $urandom_range(1, NB - 1);
                sl = (r == 9) ? TIMEOUT + $urandom_range(0, 3)
                   : (r == 8) ? TIMEOUT - 1 : $urandom_range(1, 5);
            end
            send_frame(d, sa, sl, 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        send_partial(8'h5A, 3);
        void'(expq.pop_back());
        rst_n = 1'b0;
        #2;
        chk("mid_rst_dout", 32'(dout), 32'h00);
        chk("mid_rst_slot", 32'(slot), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        last_good = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        send_frame(8'hC3, -1, 0, 1'b0);
        idle(5);
        chk("queue_empty", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/demux_tdm_1para8.md
Name: demux_tdm_1para8

Overview:
Receive end of the 1-bit, 8-channel time-division link. The transmit side drives one slot per cycle onto a single line through the 8-to-1 mux. This block reverses that path:
- tracks slot position from a frame sync;
- demultiplexes each valid bit into a per-channel shadow register;
- presents a completed 8-bit frame with a one-cycle valid strobe.

Sits between the serial link pin and the parallel channel consumers.

Parameters:
TIMEOUT, 16, max consecutive cycles with din_valid low inside a frame before abort (1..255).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
din  input  1  serial data bit for current slot.
din_valid  input  1  din carries a slot bit this cycle; low = stall, slot does not advance.
sync  input  1  frame start; qualified only with din_valid=1; marks din as slot 0.
dout  output  8  last complete frame; bit k = slot k.
dout_valid  output  1  one-cycle pulse when dout updates.
slot  output  3  index of next slot expected (0 in HUNT).
busy  output  1  high in RECV (and PAR when enabled).
frame_err  output  1  one-cycle pulse on framing error, timeout or parity error.

Behaviour:
- Reset (async, rst_n=0):
  - dout=8'h00, dout_valid=0, frame_err=0, slot=0, busy=0;
  - state HUNT, shadow=0, timeout counter=0.
- All outputs are registered.
- States: HUNT, RECV, PAR (PAR exists only with the optional feature).
- HUNT:
  - Ignore din_valid without sync.
  - sync&din_valid: shadow[0]<=din, slot<=1, go to RECV.
- RECV, din_valid=1 and sync=0:
  - shadow[slot]<=din; the write enable is the 3-to-8 decode of slot.
  - slot<=slot+1.
  - Timeout counter clears.
- Frame completion, on the slot-7 accept:
  - Next cycle: dout={din,shadow[6:0]}, dout_valid=1, slot=0, state HUNT.
  - Latency from slot-7 bit to dout_valid is 1 cycle.
- Back-to-back frames: sync&din_valid in the cycle immediately after the slot-7 accept is accepted as slot 0 of the next frame. No dead cycle is required.
- Sync inside RECV (slot!=0 with sync&din_valid):
  - frame_err pulses; partial frame discarded; dout unchanged.
  - Re-align: shadow[0]<=din, slot<=1, stay in RECV.
- Stall (din_valid=0 in RECV):
  - slot and shadow hold; timeout counter increments.
  - Counter reaching TIMEOUT: frame_err pulse, state HUNT, slot=0, dout unchanged.
- din, sync and din_valid are ignored when din_valid=0. sync alone never acts.
- dout_valid and frame_err are never high in the same cycle; the abort path wins.
- dout holds between frames.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost.

Optional Feature:
Macro DEMUX_TDM_PARITY_EN.
- Defined:
  - The frame has a 9th slot carrying even parity over the 8 data bits.
  - After the slot-7 accept the FSM enters PAR; slot output reads 0 while in PAR.
  - The next valid bit completes the check:
    - match: dout/dout_valid update;
    - mismatch: frame_err pulse, dout unchanged.
  - Then HUNT.
  - sync in PAR is a framing error, handled as sync inside RECV.
  - Timeout applies in PAR.
- Undefined: no PAR state; completion occurs on slot 7 as above.

Decomposition:
- Shared package demux_tdm_pkg:
  - state enum (ST_HUNT, ST_RECV, ST_PAR);
  - NUM_SLOTS=8;
  - SLOT_W=3.
- Slot write-enable decoding reuses the existing Decoder_3para8 as the single sub-module, instantiated once. All else is inline.

Test Plan:
- Reset then sync+din_valid with bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles -> dout=8'h4D, dout_valid for exactly 1 cycle, one cycle after the 8th bit; slot returns to 0.
- Same frame with din_valid low for 3 cycles after slot 3 (TIMEOUT=16) -> dout=8'h4D; the stall only delays dout_valid by 3 cycles.
- Stall of 16 cycles at slot 5 -> frame_err pulse on the 16th idle cycle, busy=0, dout keeps its previous value.
- Sync re-asserted at slot 4, followed by a full valid frame 8'hA5 -> one frame_err pulse, then dout=8'hA5 with no corruption from the partial frame.
- Two frames back-to-back, 8'hFF then 8'h01, with no gap -> two dout_valid pulses 8 cycles apart.
- DEMUX_TDM_PARITY_EN: frame 8'h03 with parity 0 -> dout=8'h03. Frame 8'h07 with parity 0 -> frame_err, dout stays 8'h03.
